// File: rtl/word_tx_serializer_pkg.sv
// rtl/word_tx_serializer_pkg.sv - shared types and sizing helpers for the word serializer
package word_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int DEF_LEN   = 32;
   localparam int DEF_NBITS = 8;

   function automatic int calc_nbytes(input int len, input int nbits);
      return len / nbits;
   endfunction

   // Counter must be able to hold NBYTES itself, hence the +1.
   function automatic int calc_cnt_w(input int len, input int nbits);
      return $clog2(calc_nbytes(len, nbits) + 1);
   endfunction

   localparam int CNT_W = calc_cnt_w(DEF_LEN, DEF_NBITS);

endpackage

// File: rtl/word_tx_serializer_if.sv
// rtl/word_tx_serializer_if.sv - word handshake and UART byte bus for the serializer
interface word_tx_serializer_if
   import word_tx_pkg::*;
#(
   parameter int LEN   = DEF_LEN,
   parameter int NBITS = DEF_NBITS
);
   logic             i_word_valid;
   logic [LEN-1:0]   i_word;
   logic             o_word_ready;
   logic             o_word_sent;
   logic             o_tx_start;
   logic [NBITS-1:0] o_tx_data;
   logic             i_tx_done;
   logic             o_busy;

   modport slave (
      input  i_word_valid, i_word, i_tx_done,
      output o_word_ready, o_word_sent, o_tx_start, o_tx_data, o_busy
   );

   modport master (
      output i_word_valid, i_word, i_tx_done,
      input  o_word_ready, o_word_sent, o_tx_start, o_tx_data, o_busy
   );
endinterface

// File: rtl/word_tx_serializer.sv
// rtl/word_tx_serializer.sv - splits a LEN-bit word into UART bytes, MSB first; WORD_TX_CHECKSUM_EN appends an XOR byte
module word_tx_serializer
   import word_tx_pkg::*;
#(
   parameter int LEN   = DEF_LEN,
   parameter int NBITS = DEF_NBITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   word_tx_serializer_if.slave  bus
);
   localparam int NBYTES = calc_nbytes(LEN, NBITS);
   localparam int CW     = calc_cnt_w(LEN, NBITS);

   generate
      if ((LEN % NBITS) != 0 || LEN < NBITS) begin : g_bad_len
         $error("word_tx_serializer: LEN must be a non-zero multiple of NBITS");
      end
   endgenerate

   state_t           state;
   logic [LEN-1:0]   shreg;
   logic [LEN-1:0]   shifted;
   logic [CW-1:0]    cnt;
   logic             word_ready;
   logic             word_sent;
   logic             tx_start;
   logic [NBITS-1:0] tx_data;
   logic             busy;
`ifdef WORD_TX_CHECKSUM_EN
   logic [NBITS-1:0] xor_acc;
`endif

   assign shifted = shreg << NBITS;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         word_ready <= 1'b1;
         word_sent  <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         busy       <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
         xor_acc    <= '0;
`endif
      end else begin
         word_sent <= 1'b0;
         tx_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_word_valid) begin
                  shreg      <= bus.i_word;
                  cnt        <= CW'(NBYTES);
                  tx_data    <= bus.i_word[LEN-1 -: NBITS];
                  tx_start   <= 1'b1;
                  word_ready <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SEND;
`ifdef WORD_TX_CHECKSUM_EN
                  xor_acc    <= '0;
`endif
               end
            end
            // tx-done during the start cycle cannot be genuine, so SEND never looks at it.
            SEND: state <= WAIT;
            WAIT: begin
               if (bus.i_tx_done) begin
                  shreg <= shifted;
                  cnt   <= cnt - CW'(1);
`ifdef WORD_TX_CHECKSUM_EN
                  xor_acc <= xor_acc ^ tx_data;
`endif
                  if (cnt > CW'(1)) begin
                     tx_data  <= shifted[LEN-1 -: NBITS];
                     tx_start <= 1'b1;
                     state    <= SEND;
                  end
`ifdef WORD_TX_CHECKSUM_EN
                  // cnt==1 marks the last data byte; cnt==0 marks the checksum byte.
                  else if (cnt == CW'(1)) begin
                     tx_data  <= xor_acc ^ tx_data;
                     tx_start <= 1'b1;
                     state    <= SEND;
                  end
`endif
                  else begin
                     word_sent  <= 1'b1;
                     word_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_word_ready = word_ready;
   assign bus.o_word_sent  = word_sent;
   assign bus.o_tx_start   = tx_start;
   assign bus.o_tx_data    = tx_data;
   assign bus.o_busy       = busy;

endmodule

// File: tb/tb_word_tx_serializer.sv
// tb/tb_word_tx_serializer.sv - scoreboard bench for word_tx_serializer
module tb_word_tx_serializer;
   import word_tx_pkg::*;

   localparam int LEN   = 32;
   localparam int NBITS = 8;
   localparam int NB    = 4;
   localparam int DELAY = 10;

   typedef logic [7:0] bytes_t [NB];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   word_tx_serializer_if #(.LEN(LEN), .NBITS(NBITS)) bus ();

   word_tx_serializer #(.LEN(LEN), .NBITS(NBITS)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_bytes[$];
   int         exp_len[$];

   int         starts_in_word = 0;
   int         total_starts   = 0;
   int         sent_count     = 0;
   int         last_done_cyc  = -10;
   int         last_sent_cyc  = -10;
   logic [7:0] last_byte      = 8'h00;

   bit spur_send = 1'b0;
   bit spur_idle = 1'b0;
   bit uart_busy = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected bytes and word lengths as the DUT presents them.
   always @(negedge clk) begin
      if (!rst_n) begin
         starts_in_word = 0;
      end else begin
         if (bus.o_tx_start) begin
            total_starts++;
            starts_in_word++;
            last_byte = bus.o_tx_data;
            if (exp_bytes.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start actual=%0h required=none", bus.o_tx_data);
            end else begin
               check("tx_byte", bus.o_tx_data, exp_bytes.pop_front());
            end
         end else if (bus.i_tx_done && bus.o_busy) begin
            check("held_data", bus.o_tx_data, last_byte);
            last_done_cyc = cyc;
         end
         if (bus.o_word_sent) begin
            sent_count++;
            last_sent_cyc = cyc;
            check("sent_latency", cyc, last_done_cyc + 1);
            if (exp_len.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word_sent actual=1 required=0");
            end else begin
               check("bytes_per_word", starts_in_word, exp_len.pop_front());
            end
            starts_in_word = 0;
         end
      end
   end

   // UART model: answers each start pulse with a one-cycle tx-done DELAY cycles later.
   initial begin
      bus.i_tx_done = 1'b0;
      @(posedge clk); #1;
      forever begin
         if (bus.o_tx_start) begin
            uart_busy = 1'b1;
            if (spur_send) bus.i_tx_done = 1'b1;
            @(posedge clk); #1;
            bus.i_tx_done = 1'b0;
            repeat (DELAY - 2) @(posedge clk);
            #1 bus.i_tx_done = 1'b1;
            @(posedge clk); #1;
            bus.i_tx_done = 1'b0;
            uart_busy = 1'b0;
         end else if (spur_idle) begin
            bus.i_tx_done = 1'b1;
            @(posedge clk); #1;
            bus.i_tx_done = 1'b0;
            spur_idle = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   task automatic send_word(input logic [31:0] w, input bytes_t b, input logic [7:0] ck,
                            input bit hold, input bit b2b);
      int  n;
      bit  rdy;
      for (int i = 0; i < NB; i++) exp_bytes.push_back(b[i]);
`ifdef WORD_TX_CHECKSUM_EN
      exp_bytes.push_back(ck);
      exp_len.push_back(NB + 1);
`else
      exp_len.push_back(NB);
      if (ck === 8'hxx) $display("unused checksum");
`endif
      bus.i_word       = w;
      bus.i_word_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         rdy = bus.o_word_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 2000);
      #1;
      if (!rdy) begin
         check("accept_timeout", 0, 1);
      end else begin
         check("first_start_latency", bus.o_tx_start, 1);
         if (b2b) check("b2b_accept_cycle", cyc, last_sent_cyc + 1);
      end
      if (!hold) bus.i_word_valid = 1'b0;
   endtask

   task automatic wait_sent(input int target);
      int n = 0;
      while (sent_count < target && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("word_sent_count", sent_count, target);
   endtask

   initial begin
      bytes_t b;
      int     s0;
      int     n;

      bus.i_word_valid = 1'b0;
      bus.i_word       = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", bus.o_word_ready, 1);
      check("rst_busy", bus.o_busy, 0);
      check("rst_start", bus.o_tx_start, 0);
      check("rst_data", bus.o_tx_data, 0);
      check("rst_sent", bus.o_word_sent, 0);
      rst_n = 1'b1;

      s0 = total_starts;
      repeat (20) @(posedge clk);
      #1;
      check("idle_no_start", total_starts - s0, 0);
      check("idle_ready", bus.o_word_ready, 1);
      check("idle_busy", bus.o_busy, 0);

      b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_word(32'hA1B2C3D4, b, 8'h04, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("busy_in_word", bus.o_busy, 1);
      check("not_ready_in_word", bus.o_word_ready, 0);
      wait_sent(1);
      check("ready_after_word", bus.o_word_ready, 1);

      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_word(32'h01020304, b, 8'h04, 1'b1, 1'b0);
      b = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
      send_word(32'hFFEEDDCC, b, 8'h00, 1'b0, 1'b1);
      wait_sent(3);

      spur_idle = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("spur_idle_busy", bus.o_busy, 0);
      check("spur_idle_sent", sent_count, 3);
      spur_send = 1'b1;
      b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_word(32'hA1B2C3D4, b, 8'h04, 1'b0, 1'b0);
      wait_sent(4);
      spur_send = 1'b0;

      s0 = total_starts;
      send_word(32'hA1B2C3D4, b, 8'h04, 1'b0, 1'b0);
      n = 0;
      while (total_starts < s0 + 2 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("reached_second_byte", total_starts - s0, 2);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.o_busy, 0);
      check("abort_ready", bus.o_word_ready, 1);
      check("abort_start", bus.o_tx_start, 0);
      exp_bytes.delete();
      exp_len.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      while (uart_busy && n < 2000) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("late_done_ignored", bus.o_busy, 0);
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_word(32'h11223344, b, 8'h44, 1'b0, 1'b0);
      wait_sent(5);

      repeat (5) @(posedge clk);
      #1;
      check("bytes_left", exp_bytes.size(), 0);
      check("words_left", exp_len.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
